conv_pe_sequencer: RTL

Main control FSM for the CNN processing-element datapath. It drives that datapath's filter/window counter enables and resets, IFMAP window-advance strobes, accumulator load and output-write strobes, sequencing per-element MACs, per-filter results, window slides and row changes. It sits beside the datapath, consumes its status flags (elco, wfco, end_of_row, stall), and exposes a start/busy/finished handshake to the top-level host.

---
 rtl/conv_ctrl_defs_pkg.sv | 20 ++
 rtl/conv_sat_counter.sv | 22 ++
 rtl/conv_pe_sequencer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/conv_ctrl_defs_pkg.sv
// Shared definitions for the CNN processing-element control path:
// state encoding, state width and the default accumulator drain depth.
package conv_ctrl_defs_pkg;

   localparam int STATE_W          = 4;
   localparam int DEF_DRAIN_CYCLES = 2;

   typedef enum logic [STATE_W-1:0] {
      ST_IDLE     = 4'd0,
      ST_INIT     = 4'd1,
      ST_COMPUTE  = 4'd2,
      ST_DRAIN    = 4'd3,
      ST_EMIT     = 4'd4,
      ST_NEXT_FLT = 4'd5,
      ST_SLIDE    = 4'd6,
      ST_ROW_END  = 4'd7,
      ST_FINISH   = 4'd8
   } state_t;

endpackage

// File: rtl/conv_sat_counter.sv
// Saturating up-counter with synchronous clear; clear has priority over count.
module conv_sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         en,
   output logic [W-1:0] count
);

   // Count enabled cycles, sticking at all-ones instead of wrapping.
   // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         count <= '0;
      end else if (en && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/conv_pe_sequencer.sv
// Main control FSM for the CNN PE datapath: sequences per-element MACs,
// accumulator drain, per-filter write-out, window slides and row changes.
// Strobes are decoded combinationally from state and stall.
module conv_pe_sequencer
   import conv_ctrl_defs_pkg::*;
#(
   parameter int ROW_W        = 8,
   parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES,
   parameter int PERF_W       = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ROW_W-1:0]  num_rows,
   input  logic              elco,
   input  logic              wfco,
   input  logic              end_of_row,
   input  logic              stall,
   output logic              rst_cnt,
   output logic              ferst,
   output logic              feen,
   output logic              wfrst,
   output logic              wfen,
   output logic              lddc,
   output logic              dsen,
   output logic              sel_next,
   output logic              woen,
   output logic              ldreg,
   output logic              done,
   output logic              busy,
   output logic              finished,
   output logic [ROW_W-1:0]  rows_done,
   output logic [PERF_W-1:0] stall_cycles
);

   localparam int DCNT_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [DCNT_W-1:0] DRAIN_LOAD = DCNT_W'(DRAIN_CYCLES - 1);

   state_t            state;
   logic [ROW_W-1:0]  num_rows_q;
   logic [ROW_W-1:0]  rows_done_q;
   logic [ROW_W-1:0]  rows_next;
   logic [DCNT_W-1:0] drain_cnt;

   assign rows_next = rows_done_q + ROW_W'(1);
   assign rows_done = rows_done_q;

   // State register, job parameters, row progress and drain countdown.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         num_rows_q  <= '0;
         rows_done_q <= '0;
         drain_cnt   <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  num_rows_q <= num_rows;
                  state      <= ST_INIT;
               end
            end
            ST_INIT: begin
               rows_done_q <= '0;
               state       <= (num_rows_q == '0) ? ST_FINISH : ST_COMPUTE;
            end
            ST_COMPUTE: begin
               // Stall wins over elco: the last element is not consumed until the datapath moves.
               if (!stall && elco) begin
                  drain_cnt <= DRAIN_LOAD;
                  state     <= ST_DRAIN;
               end
            end
            ST_DRAIN: begin
               if (!stall) begin
                  if (drain_cnt == '0) state <= ST_EMIT;
                  else                 drain_cnt <= drain_cnt - DCNT_W'(1);
               end
            end
            ST_EMIT: begin
               if (!stall) begin
                  if (!wfco)            state <= ST_NEXT_FLT;
                  else if (!end_of_row) state <= ST_SLIDE;
                  else                  state <= ST_ROW_END;
               end
            end
            ST_NEXT_FLT: state <= ST_COMPUTE;
            ST_SLIDE:    state <= ST_COMPUTE;
            ST_ROW_END: begin
               rows_done_q <= rows_next;
               state       <= (rows_next == num_rows_q) ? ST_FINISH : ST_COMPUTE;
            end
            ST_FINISH:   state <= ST_IDLE;
            default:     state <= ST_IDLE;
         endcase
      end
   end

   // Decode datapath strobes and handshake outputs from the current state.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      rst_cnt  = 1'b0;
      ferst    = 1'b0;
      feen     = 1'b0;
      wfrst    = 1'b0;
      wfen     = 1'b0;
      lddc     = 1'b0;
      dsen     = 1'b0;
      sel_next = 1'b0;
      woen     = 1'b0;
      ldreg    = 1'b0;
      done     = 1'b0;
      finished = 1'b0;
      busy     = (state != ST_IDLE);
      case (state)
         ST_INIT: begin
            rst_cnt = 1'b1;
            ferst   = 1'b1;
            wfrst   = 1'b1;
            lddc    = 1'b1;
         end
         ST_COMPUTE: begin
            feen  = !stall;
            ldreg = !stall;
         end
         ST_DRAIN:    ldreg = !stall;
         ST_EMIT:     done  = !stall;
         ST_NEXT_FLT: begin
            wfen  = 1'b1;
            ferst = 1'b1;
            lddc  = 1'b1;
         end
         ST_SLIDE: begin
            dsen  = 1'b1;
            ferst = 1'b1;
            wfrst = 1'b1;
         end
         ST_ROW_END: begin
            woen     = 1'b1;
            sel_next = 1'b1;
            ferst    = 1'b1;
            wfrst    = 1'b1;
            lddc     = 1'b1;
         end
         ST_FINISH:   finished = 1'b1;
         default: ;
      endcase
   end

   // Stalled-cycle performance counter, restarted at the beginning of each job.
   conv_sat_counter #(
      .W (PERF_W)
   ) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (state == ST_INIT),
      .en    (busy && stall),
      .count (stall_cycles)
   );

endmodule
